uart_rx_param: RTL and testbench

Parametrised UART receiver that succeeds the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count.
- 2-flop input synchroniser, 3-sample majority-vote bit decision, false-start rejection.
- Registered parity-error and framing-error flags.
- Sits between the serial pin and byte-level consumers. Pairs with uart_tx for 8N1 links; other frame formats come from any compliant transmitter.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sampler.sv | 43 ++++
 rtl/uart_rx_param.sv | 156 +++++++++++++++
 tb/tb_uart_rx_param.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver family: parity modes, receiver
// state encoding and the half-bit count used for start-bit validation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        BREAK
    } rx_state_t;

    function automatic int half_count(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser and 3-sample majority voter. The voted bit is valid in
// the cycle where bit_cnt reaches CLKS_PER_BIT-1.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_serial,
    input  logic [CNT_W-1:0] bit_cnt,
    output logic             rx_s,
    output logic             voted
);

    localparam logic [CNT_W-1:0] SAMPLE_A = CNT_W'(CLKS_PER_BIT - 3);
    localparam logic [CNT_W-1:0] SAMPLE_B = CNT_W'(CLKS_PER_BIT - 2);

    logic rx_meta;
    logic sample_a;
    logic sample_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            sample_a <= 1'b1;
            sample_b <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
            if (bit_cnt == SAMPLE_A) begin
                sample_a <= rx_s;
            end
            if (bit_cnt == SAMPLE_B) begin
                sample_b <= rx_s;
            end
        end
    end

    // Third vote is the live synchronised value at the final count.
    assign voted = (sample_a & sample_b) | (sample_a & rx_s) | (sample_b & rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// with registered parity/framing error flags and break handling.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_Dv,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Rx_Active
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT   = CNT_W'(half_count(CLKS_PER_BIT));
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP  = (STOP_BITS == 2);
    localparam logic             ODD_PARITY = (PARITY_MODE == PAR_ODD);

    rx_state_t            state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_pend;
    logic                 frame_pend;
    logic                 rx_s;
    logic                 voted;
    logic                 bit_end;

    uart_rx_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_sampler (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .rx_serial (i_Rx_Serial),
        .bit_cnt   (bit_cnt),
        .rx_s      (rx_s),
        .voted     (voted)
    );

    assign bit_end = (bit_cnt == LAST_CNT);

    // Frame sequencer; every output is registered here so consumers see
    // glitch-free flags that hold until the next completed frame.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shift_reg    <= '0;
            par_pend     <= 1'b0;
            frame_pend   <= 1'b0;
            o_Rx_Dv      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Rx_Active  <= 1'b0;
        end else begin
            o_Rx_Dv <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_s) begin
                        state       <= START;
                        o_Rx_Active <= 1'b1;
                        par_pend    <= 1'b0;
                        frame_pend  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_CNT) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state       <= IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt   <= '0;
                        shift_reg <= {voted, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_IDX) begin
                            stop_idx <= 1'b0;
                            state    <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt  <= '0;
                        par_pend <= ((^shift_reg) ^ voted) != ODD_PARITY;
                        state    <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (!voted) begin
                            frame_pend <= 1'b1;
                        end
                        if (stop_idx == LAST_STOP) begin
                            state <= DONE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    o_Rx_Dv      <= 1'b1;
                    o_Rx_Byte    <= shift_reg;
                    o_Parity_Err <= par_pend;
                    o_Frame_Err  <= frame_pend;
                    o_Rx_Active  <= 1'b0;
                    state        <= rx_s ? IDLE : BREAK;
                end
                // A line held low after a frame is a break, not a new start bit.
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1, 7E1 and 8N2 instances share one
// clock and reset; expected frames are queued as stimulus is driven.
module tb_uart_rx_param;

    localparam int CPB_A  = 87;
    localparam int CPB_B  = 16;
    localparam int CPB_C  = 20;
    localparam int HALF_A = (CPB_A - 1) / 2;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic rx_c = 1'b1;

    logic       a_dv, a_perr, a_ferr, a_active;
    logic [7:0] a_byte;
    logic       b_dv, b_perr, b_ferr, b_active;
    logic [6:0] b_byte;
    logic       c_dv, c_perr, c_ferr, c_active;
    logic [7:0] c_byte;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int vectors = 0;
    int miscompares = 0;
    int dv_a = 0, dv_b = 0, dv_c = 0;
    int total_a = 0, total_b = 0, total_c = 0;
    int run_len = 0;
    int last_len = 0;

    always #5 clock = ~clock;

    uart_rx_param #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
        .i_Clock(clock), .i_Reset(reset), .i_Rx_Serial(rx_a),
        .o_Rx_Dv(a_dv), .o_Rx_Byte(a_byte), .o_Parity_Err(a_perr),
        .o_Frame_Err(a_ferr), .o_Rx_Active(a_active)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) dut_b (
        .i_Clock(clock), .i_Reset(reset), .i_Rx_Serial(rx_b),
        .o_Rx_Dv(b_dv), .o_Rx_Byte(b_byte), .o_Parity_Err(b_perr),
        .o_Frame_Err(b_ferr), .o_Rx_Active(b_active)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB_C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dut_c (
        .i_Clock(clock), .i_Reset(reset), .i_Rx_Serial(rx_c),
        .o_Rx_Dv(c_dv), .o_Rx_Byte(c_byte), .o_Parity_Err(c_perr),
        .o_Frame_Err(c_ferr), .o_Rx_Active(c_active)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic check_dv(input int sel, input logic [8:0] data, input logic perr, input logic ferr);
        exp_t  e;
        bit    have;
        string p;
        have = 1'b0;
        case (sel)
            0: begin p = "A"; dv_a++; if (q_a.size() != 0) begin e = q_a.pop_front(); have = 1'b1; end end
            1: begin p = "B"; dv_b++; if (q_b.size() != 0) begin e = q_b.pop_front(); have = 1'b1; end end
            default: begin p = "C"; dv_c++; if (q_c.size() != 0) begin e = q_c.pop_front(); have = 1'b1; end end
        endcase
        if (!have) begin
            checkOutput($sformatf("%s unexpected dv", p), 32'd1, 32'd0);
        end else begin
            checkOutput($sformatf("%s byte", p), 32'(data), 32'(e.data));
            checkOutput($sformatf("%s parity err", p), 32'(perr), 32'(e.perr));
            checkOutput($sformatf("%s frame err", p), 32'(ferr), 32'(e.ferr));
        end
    endtask

    always @(negedge clock) if (a_dv) check_dv(0, {1'b0, a_byte}, a_perr, a_ferr);
    always @(negedge clock) if (b_dv) check_dv(1, {2'b0, b_byte}, b_perr, b_ferr);
    always @(negedge clock) if (c_dv) check_dv(2, {1'b0, c_byte}, c_perr, c_ferr);

    // Length of the most recent completed o_Rx_Active pulse on instance A.
    always @(negedge clock) begin
        if (a_active) begin
            run_len++;
        end else if (run_len != 0) begin
            last_len = run_len;
            run_len  = 0;
        end
    end

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input int sel, input logic [31:0] bits, input int nbits,
                                 input int cpb, input int spike_bit, input int spike_off);
        logic v;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clock);
                v = bits[b];
                if (b == spike_bit && c == spike_off) v = ~v;
                set_line(sel, v);
            end
        end
    endtask

    task automatic send_a(input logic [7:0] data, input logic stop_val, input int spike_bit);
        exp_t e;
        e.data = {1'b0, data};
        e.perr = 1'b0;
        e.ferr = ~stop_val;
        q_a.push_back(e);
        total_a++;
        applyStimulus(0, {22'b0, stop_val, data, 1'b0}, 10, CPB_A, spike_bit, HALF_A);
    endtask

    task automatic send_b(input logic [6:0] data, input logic pbit);
        exp_t e;
        e.data = {2'b0, data};
        e.perr = (^data) ^ pbit;
        e.ferr = 1'b0;
        q_b.push_back(e);
        total_b++;
        applyStimulus(1, {22'b0, 1'b1, pbit, data, 1'b0}, 10, CPB_B, -1, 0);
    endtask

    task automatic push_c(input logic [7:0] data);
        exp_t e;
        e.data = {1'b0, data};
        e.perr = 1'b0;
        e.ferr = 1'b0;
        q_c.push_back(e);
        total_c++;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] r;
        logic [6:0] r7;
        int         hits;

        wait_cycles(5);
        checkOutput("reset A dv", 32'(a_dv), 32'd0);
        checkOutput("reset A byte", 32'(a_byte), 32'd0);
        checkOutput("reset A perr", 32'(a_perr), 32'd0);
        checkOutput("reset A ferr", 32'(a_ferr), 32'd0);
        checkOutput("reset A active", 32'(a_active), 32'd0);
        checkOutput("reset B byte", 32'(b_byte), 32'd0);
        checkOutput("reset C byte", 32'(c_byte), 32'd0);
        reset = 1'b0;
        wait_cycles(10);

        // 8N1 frames, including the 0xAB reference frame and its active window
        last_len = 0;
        send_a(8'hAB, 1'b1, -1);
        wait_cycles(CPB_A);
        hits = (last_len >= 9 * CPB_A + HALF_A && last_len <= 9 * CPB_A + HALF_A + 4) ? 1 : 0;
        checkOutput("A active length in range", 32'(hits), 32'd1);
        send_a(8'h00, 1'b1, -1);
        send_a(8'hFF, 1'b1, -1);
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom);
            send_a(r, 1'b1, -1);
        end
        wait_cycles(CPB_A);

        // 7E1 frames with good and bad parity bits
        send_b(7'h55, 1'b0);
        send_b(7'h55, 1'b1);
        for (int i = 0; i < 3; i++) begin
            r7 = 7'($urandom);
            send_b(r7, 1'($urandom));
        end
        wait_cycles(CPB_B * 2);

        // 8N2 back-to-back frames with no idle gap, then one more
        push_c(8'h00);
        push_c(8'hFF);
        applyStimulus(2, {10'b0, 2'b11, 8'hFF, 1'b0, 2'b11, 8'h00, 1'b0}, 22, CPB_C, -1, 0);
        r = 8'($urandom);
        push_c(r);
        applyStimulus(2, {19'b0, 2'b11, r, 1'b0}, 11, CPB_C, -1, 0);
        wait_cycles(CPB_C * 2);

        // Framing error followed by a 3-bit break; no second pulse until a new start
        send_a(8'h96, 1'b0, -1);
        applyStimulus(0, 32'h0, 3, CPB_A, -1, 0);
        set_line(0, 1'b1);
        wait_cycles(CPB_A * 2);
        checkOutput("A dv count after break", 32'(dv_a), 32'(total_a));
        send_a(8'h12, 1'b1, -1);
        wait_cycles(CPB_A);

        // False start: 20-cycle low glitch on an idle line
        last_len = 0;
        set_line(0, 1'b0);
        wait_cycles(20);
        set_line(0, 1'b1);
        wait_cycles(CPB_A * 2);
        hits = (last_len >= 1 && last_len <= HALF_A + 3) ? 1 : 0;
        checkOutput("A glitch active pulse", 32'(hits), 32'd1);
        checkOutput("A dv count after glitch", 32'(dv_a), 32'(total_a));

        // Single-cycle high spike in the middle of data bit 1 of 0xF0
        send_a(8'hF0, 1'b1, 2);
        wait_cycles(CPB_A);

        // Reset during data bit 4 of 0x3C, then a clean 0xC3
        applyStimulus(0, {27'b0, 4'hC, 1'b0}, 5, CPB_A, -1, 0);
        set_line(0, 1'b1);
        wait_cycles(CPB_A / 2);
        reset = 1'b1;
        wait_cycles(2);
        checkOutput("midreset A dv", 32'(a_dv), 32'd0);
        checkOutput("midreset A byte", 32'(a_byte), 32'd0);
        checkOutput("midreset A active", 32'(a_active), 32'd0);
        checkOutput("midreset A ferr", 32'(a_ferr), 32'd0);
        set_line(0, 1'b1);
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(CPB_A * 2);
        checkOutput("A dv count after reset", 32'(dv_a), 32'(total_a));
        send_a(8'hC3, 1'b1, -1);
        wait_cycles(CPB_A * 2);

        checkOutput("A frames delivered", 32'(dv_a), 32'(total_a));
        checkOutput("B frames delivered", 32'(dv_b), 32'(total_b));
        checkOutput("C frames delivered", 32'(dv_c), 32'(total_c));
        checkOutput("A queue drained", 32'(q_a.size()), 32'd0);
        checkOutput("B queue drained", 32'(q_b.size()), 32'd0);
        checkOutput("C queue drained", 32'(q_c.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
